// File: rtl/csa23_share_arbiter.sv
// Round-robin share of one 23-bit carry-select adder among NREQ valid/ready requesters.
// Accept in cycle T -> registered result in T+1; while the result is held (rsp_ready=0) no request is accepted.
module carry_select_adder_23_bit (
  input  logic [22:0] a,
  input  logic [22:0] b,
  input  logic        cin,
  output logic [22:0] sum,
  output logic        cout
);
  // 3-bit ripple head, then five 4-bit blocks each precomputing both carry-in cases
  always_comb begin
    logic [3:0] head;
    logic [4:0] s0;
    logic [4:0] s1;
    logic       c;
    sum  = '0;
    s0   = '0;
    s1   = '0;
    head = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'b000, cin};
    sum[2:0] = head[2:0];
    c        = head[3];
    for (int k = 0; k < 5; k++) begin
      s0 = {1'b0, a[3+4*k +: 4]} + {1'b0, b[3+4*k +: 4]};
      s1 = {1'b0, a[3+4*k +: 4]} + {1'b0, b[3+4*k +: 4]} + 5'd1;
      sum[3+4*k +: 4] = c ? s1[3:0] : s0[3:0];
      c               = c ? s1[4]   : s0[4];
    end
    cout = c;
  end
endmodule

module csa23_share_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 23,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_cout
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_q;
  logic [IDW-1:0]   last_q;
  logic [IDW-1:0]   id_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic             found;
  logic [IDW-1:0]   winner;
  logic             can_issue;
  logic             accept;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic             cin_sel;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  // Pointer taken modulo NREQ so unreachable codes still yield a legal search
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_q) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  // rst_n gates issue so nothing is offered while reset is held
  assign can_issue = rst_n & ((state_q == EMPTY) | (rsp_ready & (state_q == FULL)));

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = can_issue & found & (winner == IDW'(i));
    end
  end

  assign accept = |(req_valid & req_ready);

  always_comb begin
    a_sel   = '0;
    b_sel   = '0;
    cin_sel = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == IDW'(i)) begin
        a_sel   = req_a[i*WIDTH +: WIDTH];
        b_sel   = req_b[i*WIDTH +: WIDTH];
        cin_sel = req_cin[i];
      end
    end
  end

  carry_select_adder_23_bit u_adder (
    .a    (a_sel),
    .b    (b_sel),
    .cin  (cin_sel),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      last_q  <= IDW'(NREQ - 1);
      id_q    <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_q <= FULL;
            sum_q   <= add_sum;
            cout_q  <= add_cout;
            id_q    <= winner;
            last_q  <= winner;
          end
        end
        FULL: begin
          if (accept) begin
            sum_q  <= add_sum;
            cout_q <= add_cout;
            id_q   <= winner;
            last_q <= winner;
          end else if (rsp_ready) begin
            state_q <= EMPTY;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;
endmodule

// File: tb/tb_csa23_share_arbiter.sv
// Bench for csa23_share_arbiter: vector table, directed multi-cycle sequences,
// and a random run against a queue-based reference model.
module tb_csa23_share_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 23;
  localparam int IDW  = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*W-1:0]    req_a;
  logic [NREQ*W-1:0]    req_b;
  logic [NREQ-1:0]      req_cin;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [W-1:0]         rsp_sum;
  logic                 rsp_cout;

  logic [W-1:0]         ta[NREQ];
  logic [W-1:0]         tbv[NREQ];
  logic [NREQ-1:0]      tcin;

  int n_pass = 0;
  int n_chk  = 0;

  typedef struct {
    int         id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic       cin;
    logic [W-1:0] s;
    logic       co;
  } vec_t;

  typedef struct {
    int          id;
    logic [23:0] res;
  } rec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = ta[i];
      req_b[i*W +: W] = tbv[i];
    end
  end
  assign req_cin = tcin;

  csa23_share_arbiter #(.NREQ(NREQ), .WIDTH(W), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  function automatic logic [23:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    return 24'(a) + 24'(b) + 24'(c);
  endfunction

  function automatic logic [W-1:0] rnd23();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return 23'h7FFFFF;
      default: return 23'($urandom);
    endcase
  endfunction

  task automatic new_ops(input int i);
    ta[i]   = rnd23();
    tbv[i]  = rnd23();
    tcin[i] = 1'($urandom_range(0, 1));
  endtask

  function automatic logic [31:0] rsp_word();
    return {8'h0, rsp_cout, rsp_sum};
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] expres;
    logic [31:0] snap;
    logic [1:0]  snap_id;
    int          w;
    int          nacc;
    bit          got;
    bit          m_full;
    int          m_last;
    rec_t        sbq[$];
    logic [NREQ-1:0] pv;
    logic [NREQ-1:0] acc_prev;
    int          n_acc;
    int          dut_acc;
    int          dut_rsp;
    logic [3:0]  exp_rdy;

    vecs[0] = '{2, 23'h7FFFFF, 23'h000001, 1'b0, 23'h000000, 1'b1};
    vecs[1] = '{2, 23'h123456, 23'h111111, 1'b1, 23'h234568, 1'b0};
    vecs[2] = '{0, 23'h000000, 23'h000000, 1'b0, 23'h000000, 1'b0};
    vecs[3] = '{1, 23'h7FFFFF, 23'h7FFFFF, 1'b1, 23'h7FFFFF, 1'b1};
    vecs[4] = '{3, 23'h400000, 23'h400000, 1'b0, 23'h000000, 1'b1};
    vecs[5] = '{3, 23'h0ABCDE, 23'h000000, 1'b1, 23'h0ABCDF, 1'b0};
    vecs[6] = '{0, 23'h7FFFFE, 23'h000000, 1'b1, 23'h7FFFFF, 1'b0};

    rst_n     = 1'b0;
    rsp_ready = 1'b0;
    tcin      = '0;
    for (int i = 0; i < NREQ; i++) begin
      ta[i]  = '0;
      tbv[i] = '0;
    end
    req_valid = 4'hF;
    #3;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_valid", 32'(rsp_valid), 32'h0);
    chk("rst_id", 32'(rsp_id), 32'h0);
    chk("rst_result", rsp_word(), 32'h0);

    // Round-robin from reset with all four requesting
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) new_ops(i);
    for (int c = 0; c < 8; c++) begin
      #1;
      w = c % NREQ;
      chk("rr_ready", 32'(req_ready), 32'(1 << w));
      expres = ref_add(ta[w], tbv[w], tcin[w]);
      @(negedge clk);
      chk("rr_valid", 32'(rsp_valid), 32'h1);
      chk("rr_id", 32'(rsp_id), 32'(w));
      chk("rr_result", rsp_word(), 32'(expres));
      new_ops(w);
    end

    // Backpressure: hold for five cycles, then drop+accept together
    rsp_ready = 1'b0;
    snap      = rsp_word();
    snap_id   = rsp_id;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_ready", 32'(req_ready), 32'h0);
      @(negedge clk);
      chk("bp_valid", 32'(rsp_valid), 32'h1);
      chk("bp_hold_result", rsp_word(), snap);
      chk("bp_hold_id", 32'(rsp_id), 32'(snap_id));
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(req_ready), 32'h1);
    expres = ref_add(ta[0], tbv[0], tcin[0]);
    @(negedge clk);
    chk("bp_release_valid", 32'(rsp_valid), 32'h1);
    chk("bp_release_id", 32'(rsp_id), 32'h0);
    chk("bp_release_result", rsp_word(), 32'(expres));
    new_ops(0);

    // Asynchronous reset while holding a non-zero result from requester 1
    ta[1] = 23'h7FFFFF; tbv[1] = 23'h7FFFFF; tcin[1] = 1'b1;
    #1;
    chk("pre_rst_ready", 32'(req_ready), 32'h2);
    @(negedge clk);
    chk("pre_rst_result", rsp_word(), 32'hFFFFFF);
    chk("pre_rst_id", 32'(rsp_id), 32'h1);
    rsp_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 32'h0);
    chk("mid_rst_id", 32'(rsp_id), 32'h0);
    chk("mid_rst_result", rsp_word(), 32'h0);
    chk("mid_rst_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    chk("post_rst_valid", 32'(rsp_valid), 32'h1);
    chk("post_rst_id", 32'(rsp_id), 32'h0);
    rsp_ready = 1'b1;
    req_valid = '0;
    @(negedge clk);
    chk("drain_valid", 32'(rsp_valid), 32'h0);

    // Vector table, one requester at a time, junk on the other lanes
    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < NREQ; i++) new_ops(i);
      ta[vecs[v].id]   = vecs[v].a;
      tbv[vecs[v].id]  = vecs[v].b;
      tcin[vecs[v].id] = vecs[v].cin;
      req_valid = 4'(1 << vecs[v].id);
      #1;
      chk("tbl_ready", 32'(req_ready), 32'(1 << vecs[v].id));
      @(negedge clk);
      req_valid = '0;
      chk("tbl_valid", 32'(rsp_valid), 32'h1);
      chk("tbl_id", 32'(rsp_id), 32'(vecs[v].id));
      chk("tbl_result", rsp_word(), {8'h0, vecs[v].co, vecs[v].s});
    end
    @(negedge clk);
    chk("tbl_drain_valid", 32'(rsp_valid), 32'h0);

    // Fairness: requester 0 always requesting, requester 3 raises once
    req_valid = 4'b0001;
    repeat (2) @(negedge clk);
    req_valid = 4'b1001;
    nacc = 0;
    got  = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      #1;
      if (req_ready != '0) nacc++;
      if (req_ready[3]) got = 1'b1;
      @(negedge clk);
      if (got) req_valid[3] = 1'b0;
    end
    chk("fair_req3_within_4", 32'(got && nacc <= NREQ), 32'h1);
    req_valid = '0;

    // Random scoreboard
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    m_full   = 1'b0;
    m_last   = NREQ - 1;
    pv       = '0;
    acc_prev = '0;
    n_acc    = 0;
    dut_acc  = 0;
    dut_rsp  = 0;
    sbq.delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      chk("rnd_valid", 32'(rsp_valid), 32'(m_full));
      if (m_full && sbq.size() > 0) begin
        chk("rnd_id", 32'(rsp_id), 32'(sbq[0].id));
        chk("rnd_result", rsp_word(), 32'(sbq[0].res));
      end
      for (int i = 0; i < NREQ; i++) begin
        if (acc_prev[i]) pv[i] = 1'b0;
        if (!pv[i] && $urandom_range(0, 2) == 0) begin
          pv[i] = 1'b1;
          new_ops(i);
        end
      end
      req_valid = pv;
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      w = -1;
      for (int k = 1; k <= NREQ; k++) begin
        if (w < 0 && pv[(m_last + k) % NREQ]) w = (m_last + k) % NREQ;
      end
      exp_rdy = ((!m_full || rsp_ready) && w >= 0) ? 4'(1 << w) : 4'h0;
      chk("rnd_ready", 32'(req_ready), 32'(exp_rdy));
      if (rsp_valid && rsp_ready) dut_rsp++;
      if ((req_valid & req_ready) != '0) dut_acc++;
      if (m_full && rsp_ready) begin
        void'(sbq.pop_front());
        m_full = 1'b0;
      end
      if (exp_rdy != '0) begin
        sbq.push_back('{w, ref_add(ta[w], tbv[w], tcin[w])});
        m_full   = 1'b1;
        m_last   = w;
        acc_prev = exp_rdy;
        n_acc++;
      end else begin
        acc_prev = '0;
      end
    end
    @(negedge clk);
    chk("rnd_accept_count", 32'(dut_acc), 32'(n_acc));
    chk("rnd_response_count", 32'(dut_rsp + int'(rsp_valid)), 32'(n_acc));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/csa23_share_arbiter.md
# csa23_share_arbiter

Round-robin arbiter and sequencer that shares one `carry_select_adder_23_bit` instance among NREQ requesters using valid/ready handshakes. Each accepted request is summed by the shared adder and returned through a single registered response port tagged with the requester index. The block sits between mantissa-path clients and the one physical 23-bit adder, so that adder is never duplicated per client.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `WIDTH`, fixed 23: operand width; must match the shared adder.
- `IDW`, default $clog2(NREQ): requester-index width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  per-requester accept; one-hot or zero.
- `req_a`  in  NREQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- `req_b`  in  NREQ*WIDTH  operand B; same packing as `req_a`.
- `req_cin`  in  NREQ  per-requester carry-in.
- `rsp_valid`  out  1  response holds a valid result.
- `rsp_ready`  in  1  downstream accepts the response.
- `rsp_id`  out  IDW  index of the requester that produced the response.
- `rsp_sum`  out  WIDTH  registered sum.
- `rsp_cout`  out  1  registered carry-out.

## Operation
- State machine with two states:
  - EMPTY: result register is invalid.
  - FULL: result register is valid and `rsp_valid`=1.
- `can_issue` = (state==EMPTY) | (`rsp_ready` & state==FULL).
- Arbitration:
  - Round-robin with pointer `last` (IDW bits).
  - Search order is `last`+1, `last`+2, … modulo NREQ.
  - The first requester with `req_valid` set wins.
  - `req_ready[i]` = `can_issue` & winner==i. It is combinational from `req_valid`, `rsp_ready` and state.
  - Handshake: requester i is accepted when `req_valid[i]` & `req_ready[i]`.
- Datapath:
  - A mux selects the winner's `a`, `b` and `cin` into the shared adder.
  - The adder output is captured into `rsp_sum`/`rsp_cout` on accept.
  - The winner index is captured into `rsp_id`.
  - `last` is updated to the winner index on accept only.
- Transitions:
  - EMPTY→FULL on accept.
  - FULL→EMPTY when `rsp_ready` is set and there is no accept.
  - FULL→FULL when `rsp_ready` and an accept occur in the same cycle; the new result overwrites the old one.
  - FULL→FULL when `rsp_ready`=0. All response outputs are held stable and `req_ready`=0.
- Arithmetic:
  - {`rsp_cout`,`rsp_sum`} = a + b + cin, modulo 2^24.
  - There is no saturation and no overflow flag.
- Requester obligations:
  - Once asserted, `req_valid[i]` and its operands stay stable until accepted.
  - The arbiter does not sample operands on a cycle without accept.
- Fairness: a continuously requesting requester is accepted within NREQ accepts.
- Unused `last` codes (NREQ not a power of 2) are unreachable. The search treats the pointer modulo NREQ.

## Timing
- Reset (`rst_n`=0, asynchronous) forces:
  - state=EMPTY, `rsp_valid`=0, `rsp_sum`=0, `rsp_cout`=0, `rsp_id`=0.
  - `last`=NREQ-1, so requester 0 has first priority after reset.
  - `req_ready`=0 while reset is asserted.
- Reset mid-operation discards any held result without handshake. Requesters not yet accepted keep requesting and are served after release.
- Latency: accept in cycle T gives `rsp_valid`=1 with the result in cycle T+1.
- Throughput is one result per cycle when `rsp_ready` stays high.
- Backpressure: while FULL and `rsp_ready`=0, no request is accepted and the response is held unchanged.
- Simultaneous requests resolve in the same cycle by round-robin order; only one accept per cycle.
- Drop and accept in the same cycle are allowed and cause no bubble.
- Critical path: `req_valid` → arbiter → operand mux → 23-bit adder → result register, in one cycle.

## Test plan
- Reset/idle:
  - Stimulus: assert `rst_n`=0 mid-burst with `rsp_valid`=1.
  - Required response: `rsp_valid`, `rsp_sum`, `rsp_cout` and `rsp_id` go to 0 immediately.
  - After release, requester 0 wins first when all four request.
- Single add:
  - Stimulus: requester 2 sends a=0x7FFFFF, b=0x000001, cin=0.
  - Required response: next cycle `rsp_sum`=0x000000, `rsp_cout`=1, `rsp_id`=2.
  - Also: a=0x123456, b=0x111111, cin=1 gives `rsp_sum`=0x234568, `rsp_cout`=0.
- Round-robin:
  - Stimulus: all four requesters hold valid; `rsp_ready`=1.
  - Required response: accept order 0,1,2,3,0,1…, one accept per cycle, with no bubble.
- Backpressure:
  - Stimulus: `rsp_ready`=0 for 5 cycles while FULL.
  - Required response: `req_ready`=0 and the response is held bit-stable.
  - On the first `rsp_ready`=1 cycle, drop and accept happen together and a new result appears the next cycle.
- Fairness under skew:
  - Stimulus: requester 0 requests every cycle; requester 3 raises a single request.
  - Required response: requester 3 is accepted within 4 accepts.
- Random scoreboard:
  - Stimulus: 10k random operands, carries, valids and `rsp_ready`.
  - Required response: every accepted request yields exactly one response with a correct sum and id, in acceptance order.
